// File: rtl/control_unit.sv
// Multicycle main control FSM: decodes opcode/funct and sequences each instruction through
// its states, driving datapath write enables, ALU operation and every mux select.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       mdr_write,
    output logic       mux_iord_control,
    output logic       mux_aluSrcA_control,
    output logic [1:0] mux_aluSrcB_control,
    output logic [1:0] mux_regDest_control,
    output logic [1:0] mux_memToReg_control,
    output logic [1:0] mux_pcSrc_control,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic [4:0] state_out
);

    typedef enum logic [4:0] {
        st_reset      = 5'd0,
        st_fetch      = 5'd1,
        st_fetch_wait = 5'd2,
        st_decode     = 5'd3,
        st_r_exec     = 5'd4,
        st_r_wb       = 5'd5,
        st_addi_exec  = 5'd6,
        st_addi_wb    = 5'd7,
        st_mem_addr   = 5'd8,
        st_lw_read    = 5'd9,
        st_lw_wait    = 5'd10,
        st_lw_wb      = 5'd11,
        st_sw_write   = 5'd12,
        st_branch     = 5'd13,
        st_jump       = 5'd14,
        st_jal        = 5'd15,
        st_jr         = 5'd16,
        st_illegal    = 5'd17
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= st_reset;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_out = state_q;

    always_comb begin
        state_d              = state_q;
        pc_write             = 1'b0;
        ir_write             = 1'b0;
        mem_write            = 1'b0;
        reg_write            = 1'b0;
        ab_write             = 1'b0;
        aluout_write         = 1'b0;
        mdr_write            = 1'b0;
        mux_iord_control     = 1'b0;
        mux_aluSrcA_control  = 1'b0;
        mux_aluSrcB_control  = 2'b00;
        mux_regDest_control  = 2'b00;
        mux_memToReg_control = 2'b00;
        mux_pcSrc_control    = 2'b00;
        alu_op               = ALU_NONE;
        illegal_op           = 1'b0;

        unique case (state_q)
            st_reset: begin
                state_d = st_fetch;
            end
            st_fetch: begin
                mux_aluSrcB_control = 2'b01;
                alu_op              = ALU_ADD;
                pc_write            = 1'b1;
                state_d             = st_fetch_wait;
            end
            st_fetch_wait: begin
                // Memory read data arrives one cycle after the address.
                ir_write = 1'b1;
                state_d  = st_decode;
            end
            st_decode: begin
                // Branch target is precomputed into ALUOut while A/B are loaded.
                mux_aluSrcB_control = 2'b11;
                alu_op              = ALU_ADD;
                aluout_write        = 1'b1;
                ab_write            = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_d = st_r_exec;
                            FN_JR:                                 state_d = st_jr;
                            default:                               state_d = st_illegal;
                        endcase
                    end
                    OP_ADDI:       state_d = st_addi_exec;
                    OP_LW, OP_SW:  state_d = st_mem_addr;
                    OP_BEQ, OP_BNE: state_d = st_branch;
                    OP_J:          state_d = st_jump;
                    OP_JAL:        state_d = st_jal;
                    default:       state_d = st_illegal;
                endcase
            end
            st_r_exec: begin
                mux_aluSrcA_control = 1'b1;
                aluout_write        = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_NONE;
                endcase
                state_d = st_r_wb;
            end
            st_r_wb: begin
                mux_regDest_control = 2'b01;
                reg_write           = 1'b1;
                state_d             = st_fetch;
            end
            st_addi_exec, st_mem_addr: begin
                mux_aluSrcA_control = 1'b1;
                mux_aluSrcB_control = 2'b10;
                alu_op              = ALU_ADD;
                aluout_write        = 1'b1;
                if (state_q == st_addi_exec) begin
                    state_d = st_addi_wb;
                end else begin
                    state_d = (opcode == OP_SW) ? st_sw_write : st_lw_read;
                end
            end
            st_addi_wb: begin
                reg_write = 1'b1;
                state_d   = st_fetch;
            end
            st_lw_read: begin
                mux_iord_control = 1'b1;
                state_d          = st_lw_wait;
            end
            st_lw_wait: begin
                mux_iord_control = 1'b1;
                mdr_write        = 1'b1;
                state_d          = st_lw_wb;
            end
            st_lw_wb: begin
                mux_memToReg_control = 2'b01;
                reg_write            = 1'b1;
                state_d              = st_fetch;
            end
            st_sw_write: begin
                mux_iord_control = 1'b1;
                mem_write        = 1'b1;
                state_d          = st_fetch;
            end
            st_branch: begin
                // The only Mealy output: taken/not-taken follows this cycle's zero flag.
                mux_aluSrcA_control = 1'b1;
                alu_op              = ALU_SUB;
                mux_pcSrc_control   = 2'b01;
                if (opcode == OP_BEQ) begin
                    pc_write = alu_zero;
                end else if (opcode == OP_BNE) begin
                    pc_write = ~alu_zero;
                end
                state_d = st_fetch;
            end
            st_jump: begin
                mux_pcSrc_control = 2'b10;
                pc_write          = 1'b1;
                state_d           = st_fetch;
            end
            st_jal: begin
                // PC already holds PC+4 here, so it is the link value for $31.
                mux_regDest_control  = 2'b10;
                mux_memToReg_control = 2'b10;
                reg_write            = 1'b1;
                mux_pcSrc_control    = 2'b10;
                pc_write             = 1'b1;
                state_d              = st_fetch;
            end
            st_jr: begin
                mux_pcSrc_control = 2'b11;
                pc_write          = 1'b1;
                state_d           = st_fetch;
            end
            st_illegal: begin
                illegal_op = 1'b1;
                state_d    = st_fetch;
            end
            default: begin
                state_d = st_reset;
            end
        endcase
    end

endmodule
